gerador_pulso_cm: RTL and testbench

Echo-pulse generator for the ultrasonic distance path. It emulates the sensor side of the echo interface. On a trigger, it latches a 3-digit BCD distance and drives an echo pulse that lasts exactly distance × R clock cycles, i.e. one tick per centimetre. It sits in the test/emulation harness, directly feeding the echo input of the centimetre-counting measurement block.

---
 rtl/gerador_pulso_cm_pkg.sv | 39 +++
 rtl/gerador_pulso_cm_tick.sv | 30 +++
 rtl/gerador_pulso_cm.sv | 111 +++++++++++
 tb/tb_gerador_pulso_cm.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gerador_pulso_cm_pkg.sv
// rtl/gerador_pulso_cm_pkg.sv - shared state encodings, debug codes and BCD helpers
// Build option: GERADOR_PULSO_CM_ATRASO_EN enables the espera state in the top.
package gerador_pulso_cm_pkg;

  typedef enum logic [2:0] {
    ST_INICIAL    = 3'd0,
    ST_CARREGA    = 3'd1,
    ST_ESPERA     = 3'd2,
    ST_GERA_PULSO = 3'd3,
    ST_FINAL      = 3'd4
  } estado_t;

  localparam logic [3:0] DB_INICIAL    = 4'b0000;
  localparam logic [3:0] DB_CARREGA    = 4'b0001;
  localparam logic [3:0] DB_ESPERA     = 4'b0010;
  localparam logic [3:0] DB_GERA_PULSO = 4'b0011;
  localparam logic [3:0] DB_FINAL      = 4'b0100;
  localparam logic [3:0] DB_INVALIDO   = 4'b1110;

  localparam logic [3:0] DIGITO_MAX = 4'd9;

  function automatic logic [3:0] satura_digito(input logic [3:0] d);
    return (d > DIGITO_MAX) ? DIGITO_MAX : d;
  endfunction

  function automatic logic [3:0] db_codigo(input estado_t e);
    logic [3:0] c;
    case (e)
      ST_INICIAL:    c = DB_INICIAL;
      ST_CARREGA:    c = DB_CARREGA;
      ST_ESPERA:     c = DB_ESPERA;
      ST_GERA_PULSO: c = DB_GERA_PULSO;
      ST_FINAL:      c = DB_FINAL;
      default:       c = DB_INVALIDO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/gerador_pulso_cm_tick.sv
// rtl/gerador_pulso_cm_tick.sv - modulo-R tick counter, fim marks the last cycle of each period
// Build option GERADOR_PULSO_CM_ATRASO_EN does not affect this module.
module gerador_pulso_cm_tick #(
  parameter int unsigned R = 2941
) (
  input  logic clock,
  input  logic reset,
  input  logic i_zera,
  input  logic i_conta,
  output logic o_fim
);

  localparam int unsigned W = (R > 1) ? $clog2(R) : 1;
  localparam logic [W-1:0] ULTIMO = W'(R - 1);

  logic [W-1:0] r_conta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_conta <= '0;
    end else if (i_zera) begin
      r_conta <= '0;
    end else if (i_conta) begin
      r_conta <= (r_conta == ULTIMO) ? '0 : r_conta + W'(1);
    end
  end

  assign o_fim = i_conta && (r_conta == ULTIMO);

endmodule

// File: rtl/gerador_pulso_cm.sv
// rtl/gerador_pulso_cm.sv - echo-pulse generator, pulse width = BCD distance x R cycles
// Build option: GERADOR_PULSO_CM_ATRASO_EN adds the espera state (ATRASO cycles before the echo).
module gerador_pulso_cm
  import gerador_pulso_cm_pkg::*;
#(
  parameter int unsigned R = 2941
`ifdef GERADOR_PULSO_CM_ATRASO_EN
  , parameter int unsigned ATRASO = 500
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        gatilho,
  input  logic [11:0] distancia_bcd,
  output logic        pulso,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  estado_t     r_estado;
  estado_t     w_proximo;
  logic [11:0] r_bcd;
  logic [11:0] w_bcd_carga;
  logic [11:0] w_bcd_dec;
  logic        w_tick;

  assign w_bcd_carga = {satura_digito(distancia_bcd[11:8]),
                        satura_digito(distancia_bcd[7:4]),
                        satura_digito(distancia_bcd[3:0])};

  gerador_pulso_cm_tick #(.R(R)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .i_zera  (r_estado != ST_GERA_PULSO),
    .i_conta (r_estado == ST_GERA_PULSO),
    .o_fim   (w_tick)
  );

`ifdef GERADOR_PULSO_CM_ATRASO_EN
  localparam int unsigned AW = $clog2(ATRASO + 1);
  logic [AW-1:0] r_atraso;
  logic          w_atraso_fim;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_atraso <= '0;
    end else if (r_estado == ST_ESPERA) begin
      r_atraso <= r_atraso + AW'(1);
    end else begin
      r_atraso <= '0;
    end
  end

  assign w_atraso_fim = (r_atraso == AW'(ATRASO - 1));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= ST_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      ST_INICIAL: if (gatilho) w_proximo = ST_CARREGA;
`ifdef GERADOR_PULSO_CM_ATRASO_EN
      ST_CARREGA: w_proximo = ST_ESPERA;
      // a zero distance still waits out the burst delay, then reports done
      ST_ESPERA:  if (w_atraso_fim) w_proximo = (r_bcd == 12'h000) ? ST_FINAL : ST_GERA_PULSO;
`else
      ST_CARREGA: w_proximo = (w_bcd_carga == 12'h000) ? ST_FINAL : ST_GERA_PULSO;
`endif
      ST_GERA_PULSO: if (w_tick && (r_bcd == 12'h001)) w_proximo = ST_FINAL;
      ST_FINAL:      w_proximo = ST_INICIAL;
      default:       w_proximo = ST_INICIAL;
    endcase
  end

  always_comb begin
    w_bcd_dec = r_bcd;
    if (r_bcd[3:0] != 4'd0) begin
      w_bcd_dec[3:0] = r_bcd[3:0] - 4'd1;
    end else begin
      w_bcd_dec[3:0] = DIGITO_MAX;
      if (r_bcd[7:4] != 4'd0) begin
        w_bcd_dec[7:4] = r_bcd[7:4] - 4'd1;
      end else begin
        w_bcd_dec[7:4]  = DIGITO_MAX;
        w_bcd_dec[11:8] = r_bcd[11:8] - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bcd <= '0;
    end else if (r_estado == ST_CARREGA) begin
      r_bcd <= w_bcd_carga;
    end else if ((r_estado == ST_GERA_PULSO) && w_tick) begin
      r_bcd <= w_bcd_dec;
    end
  end

  assign pulso     = (r_estado == ST_GERA_PULSO);
  assign pronto    = (r_estado == ST_FINAL);
  assign db_estado = db_codigo(r_estado);

endmodule

// File: tb/tb_gerador_pulso_cm.sv
// tb/tb_gerador_pulso_cm.sv - scoreboard bench for gerador_pulso_cm (R=4, ATRASO=3)
// Works with or without GERADOR_PULSO_CM_ATRASO_EN defined.
module tb_gerador_pulso_cm;

  localparam int R_TB = 4;
  localparam int ATRASO_TB = 3;
`ifdef GERADOR_PULSO_CM_ATRASO_EN
  localparam int LAT = ATRASO_TB + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        gatilho = 1'b0;
  logic [11:0] distancia_bcd = 12'h000;
  logic        pulso;
  logic        pronto;
  logic [3:0]  db_estado;

  gerador_pulso_cm #(
    .R(R_TB)
`ifdef GERADOR_PULSO_CM_ATRASO_EN
    , .ATRASO(ATRASO_TB)
`endif
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .gatilho       (gatilho),
    .distancia_bcd (distancia_bcd),
    .pulso         (pulso),
    .pronto        (pronto),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int largura;
    int atraso;
  } esp_t;

  esp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string nome, input int atual, input int esperado);
    n_tests++;
    if (atual != esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
    end
  endtask

  // monitor: measures rise delay and width, compares on each pronto strobe
  bit seen = 0;
  int since = 0;
  int width = 0;
  int rise = 0;
  bit prev_p = 0;
  bit prev_r = 0;

  always @(negedge clock) begin
    if (reset) begin
      seen = 0; since = 0; width = 0; rise = 0; prev_p = 0; prev_r = 0;
    end else begin
      if (pronto) begin
        check("pronto_single_cycle", int'(prev_r), 0);
        if (exp_q.size() == 0) begin
          check("pronto_unexpected", 1, 0);
        end else begin
          esp_t e;
          e = exp_q.pop_front();
          check("pulse_width", width, e.largura);
          if (e.largura != 0) begin
            check("rise_delay", rise, e.atraso);
            check("pronto_after_fall", int'(prev_p), 1);
          end
        end
        seen = 0;
      end
      if (db_estado == 4'b0001) begin
        seen = 1; since = 0; width = 0; rise = 0;
      end else if (seen) begin
        since++;
        if (pulso && !prev_p) rise = since;
      end
      if (pulso) width++;
      prev_p = pulso;
      prev_r = pronto;
    end
  end

  task automatic wait_estado(input logic [3:0] code, input int budget, input string nome);
    int n = 0;
    while (db_estado !== code && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(nome, int'(db_estado), int'(code));
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic mede(input logic [11:0] bcd, input int largura, input bit drena);
    wait_estado(4'b0000, 100, "idle_before");
    exp_q.push_back('{largura, LAT});
    @(posedge clock); #1;
    distancia_bcd = bcd;
    gatilho = 1'b1;
    @(posedge clock); #1;
    gatilho = 1'b0;
    if (drena) wait_drain(6000);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    check("rst_pulso", int'(pulso), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_db_estado", int'(db_estado), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_stays_inicial", int'(db_estado), 0);
    end

    mede(12'h005, 5 * R_TB, 1'b1);
    mede(12'h123, 123 * R_TB, 1'b1);
    mede(12'h100, 100 * R_TB, 1'b1);
    mede(12'h000, 0, 1'b1);
    wait_estado(4'b0000, 20, "zero_back_to_inicial");
    mede(12'h0A5, 95 * R_TB, 1'b1);
    mede(12'h9F9, 999 * R_TB, 1'b1);

    // gatilho held: back-to-back measurements
    wait_estado(4'b0000, 100, "idle_before_b2b");
    exp_q.push_back('{2 * R_TB, LAT});
    exp_q.push_back('{2 * R_TB, LAT});
    @(posedge clock); #1;
    distancia_bcd = 12'h002;
    gatilho = 1'b1;
    wait_estado(4'b0100, 100, "b2b_first_final");
    @(negedge clock);
    wait_estado(4'b0001, 10, "b2b_second_carrega");
    gatilho = 1'b0;
    wait_drain(200);

    // inputs changed mid-pulse are ignored
    mede(12'h012, 12 * R_TB, 1'b0);
    n = 0;
    while (!pulso && n < 50) begin @(negedge clock); n++; end
    check("mid_pulse_started", int'(pulso), 1);
    repeat (10) @(posedge clock);
    #1;
    distancia_bcd = 12'h999;
    gatilho = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    gatilho = 1'b0;
    wait_drain(200);

    // reset mid-pulse: no pronto, immediate return to inicial
    wait_estado(4'b0000, 100, "idle_before_reset");
    @(posedge clock); #1;
    distancia_bcd = 12'h050;
    gatilho = 1'b1;
    @(posedge clock); #1;
    gatilho = 1'b0;
    n = 0;
    while (!pulso && n < 50) begin @(negedge clock); n++; end
    check("rst_test_pulse_started", int'(pulso), 1);
    repeat (5) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_pulso", int'(pulso), 0);
    check("async_rst_db_estado", int'(db_estado), 0);
    check("async_rst_pronto", int'(pronto), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("after_rst_inicial", int'(db_estado), 0);
    check("queue_empty_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
